// File: rtl/store_n_words.sv
// Parametrised FIFO word store: depth x bits buffer, registered output word,
// occupancy count, full/empty flags and sticky overflow/underflow flags.
module store_n_words #(
   parameter int unsigned bits  = 16,
   parameter int unsigned depth = 4,
   parameter int unsigned cbits = $clog2(depth) + 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Write,
   input  logic [bits-1:0]  Input,
   input  logic             Read,
   output logic [bits-1:0]  Word,
   output logic             Valid,
   output logic [cbits-1:0] Count,
   output logic             Empty,
   output logic             Full,
   output logic             Overflow,
   output logic             Underflow
);

   localparam int unsigned pbits = $clog2(depth);

   logic [bits-1:0]  mem [depth];
   logic [pbits-1:0] wp;
   logic [pbits-1:0] rp;
   logic             wr_ok;
   logic             rd_ok;

   always_comb begin
      Empty = (Count == '0);
      Full  = (Count == cbits'(depth));
      // A write into a full buffer is still accepted when a read frees a slot.
      wr_ok = Write && (!Full || Read);
      rd_ok = Read && !Empty;
   end

   always_ff @(posedge Clk) begin
      if (!Reset && wr_ok)
         mem[wp] <= Input;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         wp        <= '0;
         rp        <= '0;
         Word      <= '0;
         Valid     <= 1'b0;
         Count     <= '0;
         Overflow  <= 1'b0;
         Underflow <= 1'b0;
      end else begin
         Valid <= rd_ok;
         if (wr_ok)
            wp <= wp + 1'b1;
         if (rd_ok) begin
            Word <= mem[rp];
            rp   <= rp + 1'b1;
         end
         case ({wr_ok, rd_ok})
            2'b10:   Count <= Count + 1'b1;
            2'b01:   Count <= Count - 1'b1;
            default: Count <= Count;
         endcase
         if (Write && !wr_ok)
            Overflow <= 1'b1;
         if (Read && !rd_ok)
            Underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_store_n_words.sv
// Directed table-driven bench for store_n_words (bits=16, depth=4).
module tb_store_n_words;

   logic        Clk;
   logic        Reset;
   logic        Write;
   logic [15:0] Input;
   logic        Read;
   logic [15:0] Word;
   logic        Valid;
   logic [2:0]  Count;
   logic        Empty;
   logic        Full;
   logic        Overflow;
   logic        Underflow;

   int unsigned nvec = 0;
   int unsigned nerr = 0;

   store_n_words #(.bits(16), .depth(4)) dut (
      .Clk(Clk), .Reset(Reset), .Write(Write), .Input(Input), .Read(Read),
      .Word(Word), .Valid(Valid), .Count(Count), .Empty(Empty), .Full(Full),
      .Overflow(Overflow), .Underflow(Underflow)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic        rst, wr, rd;
      logic [15:0] din;
      logic [15:0] word;
      logic        valid;
      logic [2:0]  count;
      logic        ovf, udf;
   } vec_t;

   vec_t tbl[$];

   task automatic addv(input logic rst, input logic wr, input logic rd,
                       input logic [15:0] din, input logic [15:0] word,
                       input logic valid, input logic [2:0] count,
                       input logic ovf, input logic udf);
      vec_t v;
      v.rst = rst; v.wr = wr; v.rd = rd; v.din = din; v.word = word;
      v.valid = valid; v.count = count; v.ovf = ovf; v.udf = udf;
      tbl.push_back(v);
   endtask

   task automatic step(input logic rst, input logic wr, input logic rd,
                       input logic [15:0] din);
      @(negedge Clk);
      Reset = rst; Write = wr; Read = rd; Input = din;
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] word,
                        input logic valid, input logic [2:0] count,
                        input logic ovf, input logic udf);
      logic empty, full;
      empty = (count == 3'd0);
      full  = (count == 3'd4);
      nvec++;
      if (Word !== word || Valid !== valid || Count !== count || Empty !== empty ||
          Full !== full || Overflow !== ovf || Underflow !== udf) begin
         nerr++;
         $display("FAIL %s: got Word=%h Valid=%b Count=%0d Empty=%b Full=%b Ovf=%b Udf=%b, want Word=%h Valid=%b Count=%0d Empty=%b Full=%b Ovf=%b Udf=%b",
                  name, Word, Valid, Count, Empty, Full, Overflow, Underflow,
                  word, valid, count, empty, full, ovf, udf);
      end
   endtask

   initial begin
      Reset = 1'b1; Write = 1'b0; Read = 1'b0; Input = '0;

      // reset then idle
      addv(1,0,0,0,     0,0,0,0,0);
      addv(1,0,0,0,     0,0,0,0,0);
      for (int i = 0; i < 3; i++) addv(0,0,0,0, 0,0,0,0,0);
      // fill and drain
      for (int i = 1; i <= 4; i++) addv(0,1,0,16'(i), 0,0,3'(i),0,0);
      for (int i = 1; i <= 4; i++) addv(0,0,1,0, 16'(i),1,3'(4-i),0,0);
      // overflow then underflow
      for (int i = 1; i <= 4; i++) addv(0,1,0,16'(i), 4,0,3'(i),0,0);
      addv(0,1,0,5,     4,0,4,1,0);
      for (int i = 1; i <= 4; i++) addv(0,0,1,0, 16'(i),1,3'(4-i),1,0);
      addv(0,0,1,0,     4,0,0,1,1);
      // simultaneous at empty
      addv(1,0,0,0,     0,0,0,0,0);
      addv(0,1,1,7,     0,0,1,0,1);
      addv(0,0,1,0,     7,1,0,0,1);
      // simultaneous at full
      addv(1,0,0,0,     0,0,0,0,0);
      for (int i = 1; i <= 4; i++) addv(0,1,0,16'(i), 0,0,3'(i),0,0);
      addv(0,1,1,9,     1,1,4,0,0);
      addv(0,0,1,0,     2,1,3,0,0);
      addv(0,0,1,0,     3,1,2,0,0);
      addv(0,0,1,0,     4,1,1,0,0);
      addv(0,0,1,0,     9,1,0,0,0);
      // reset mid-operation wins over write and read
      addv(1,0,0,0,     0,0,0,0,0);
      for (int i = 1; i <= 3; i++) addv(0,1,0,16'(i), 0,0,3'(i),0,0);
      addv(1,1,1,16'h1234, 0,0,0,0,0);
      addv(0,1,0,16'hABCD, 0,0,1,0,0);
      addv(0,0,1,0,     16'hABCD,1,0,0,0);

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].din);
         check($sformatf("vec%0d", i), tbl[i].word, tbl[i].valid,
               tbl[i].count, tbl[i].ovf, tbl[i].udf);
      end

      // wrap-around streaming at occupancy 1
      step(1,0,0,0);
      check("stream_reset", 0,0,0,0,0);
      step(0,1,0,10);
      check("stream_prime", 0,0,1,0,0);
      for (int i = 11; i <= 40; i++) begin
         step(0,1,1,16'(i));
         check($sformatf("stream%0d", i), 16'(i-1),1,1,0,0);
      end
      step(0,0,1,0);
      check("stream_tail", 40,1,0,0,0);
      step(0,0,0,0);
      check("stream_idle", 40,0,0,0,0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
